operand_serializer: RTL and testbench
=====================================

Name: operand_serializer

Overview:
- Host-side transmitter for the TinyTPU serial operand interface. It drives `data_in_x`, `data_in_y`, `load_en` and `init` into the accelerator top.
- It accepts one parallel x vector and one parallel y vector per valid/ready handshake. It shifts both vectors out bit-serially on two lanes in lockstep.
- After the vector flagged last, it issues the single-cycle `init` pulse that starts the systolic computation.
- It sits in the host/FPGA wrapper in front of `top` and replaces testbench-driven serial stimulus.

Parameters:
- D_W, 8, bits per operand element
- N, 2, elements per vector (systolic array dimension)
- GAP_CYC, 2, idle cycles with `load_en`=0 between the last shifted bit and the `init` pulse (range 0..15)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- vec_valid  in  1  host presents `x_vec`/`y_vec`/`vec_last`
- vec_ready  out  1  serializer can accept a vector this cycle
- x_vec  in  N*D_W  x operands; element k = bits [k*D_W +: D_W]
- y_vec  in  N*D_W  y operands, same packing as `x_vec`
- vec_last  in  1  this vector ends the job; `init` follows it
- data_in_x  out  1  serial x lane to the accelerator
- data_in_y  out  1  serial y lane to the accelerator
- load_en  out  1  high exactly while the lanes carry valid bits
- init  out  1  one-cycle compute start pulse
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse, coincident with `init`

Behaviour:
- Reset values: `vec_ready`=1, and `data_in_x`, `data_in_y`, `load_en`, `init`, `busy`, `done` all 0. The FSM resets to IDLE and all counters clear. Reset asserted mid-operation aborts immediately with the same values; the partial vector is lost.
- All serial-side outputs are registered; no combinational path from inputs to `data_in_*`, `load_en` or `init`.
- States: IDLE, SHIFT, GAP, INIT.
- IDLE:
  - `vec_ready`=1.
  - On `vec_valid`&`vec_ready` at edge t, latch `x_vec`, `y_vec` and `vec_last` into shift registers, clear the bit counter and go to SHIFT.
  - The first bit appears on the lanes, with `load_en`=1, in the cycle after edge t.
- SHIFT:
  - Lasts exactly N*D_W cycles with `load_en`=1.
  - Bit order: element 0 first, then 1..N-1. Within each element, MSB first.
  - x and y lanes advance on the same cycle.
  - `vec_ready`=1 only in the final SHIFT cycle, and only when the latched last flag is 0. A handshake there reloads the registers, and SHIFT continues with no bubble: `load_en` stays 1.
  - After the final bit:
    - not last, no new vector → IDLE, `load_en`=0;
    - last, GAP_CYC>0 → GAP;
    - last, GAP_CYC=0 → INIT.
- GAP: `load_en`=0, lanes driven 0, `vec_ready`=0, for GAP_CYC cycles, then INIT.
- INIT: `init`=1 and `done`=1 for exactly one cycle, `vec_ready`=0, then IDLE.
- Lanes are driven 0 whenever `load_en`=0.
- `busy`=1 in SHIFT, GAP and INIT.
- Host inputs are ignored whenever `vec_ready`=0. `vec_valid` may stay high without effect.
- Bit counter width is clog2(N*D_W)+1; the gap counter is 4 bits. No wrap-around is visible externally.
- Latency, single-vector job (handshake at edge t): bits occupy cycles t+1..t+N*D_W, and `init` occurs in cycle t+N*D_W+GAP_CYC+1.

Test Plan:
- Serial encoding and timing:
  - Stimulus: reset, then a single vector with N=2, D_W=8, `x_vec`=16'h0381, `y_vec`=16'h7F00, `vec_last`=1, GAP_CYC=2.
  - Required: `data_in_x` = 1,0,0,0,0,0,0,1, 0,0,0,0,0,0,1,1; `data_in_y` = 8×0, then 0,1,1,1,1,1,1,1; `load_en` high for exactly 16 cycles; two idle cycles; `init`/`done` high 1 cycle, 19 cycles after the handshake.
- Back-to-back vectors:
  - Stimulus: three vectors with `vec_valid` held high, last flag on the third only.
  - Required: `load_en` continuously high for 48 cycles; `vec_ready` pulses in shift cycles 16 and 32 only; a single `init` pulse after the gap.
- Non-last idle:
  - Stimulus: one vector with `vec_last`=0.
  - Required: 16 bits are shifted; no `init` pulse; the block returns to IDLE with `vec_ready`=1 and `busy`=0.
- GAP_CYC=0:
  - Stimulus: a last vector.
  - Required: `init` in the cycle immediately after the final bit; `load_en` and `init` are never high together.
- Reset mid-shift:
  - Stimulus: assert `rst` at bit 5 of a last vector.
  - Required: all outputs 0 and `vec_ready`=1 asynchronously; no `init` pulse. A following vector shifts from element 0 MSB correctly.
- Ignored valid:
  - Stimulus: toggle `vec_valid` and `x_vec` during SHIFT and GAP.
  - Required: the lane bitstream is unchanged from the latched values.

Source files
------------

// File: rtl/operand_serializer_if.sv
// Host-to-serializer bundle: parallel vector handshake in, serial operand lanes and status out.
interface operand_serializer_if #(
    parameter int D_W = 8,
    parameter int N   = 2
);
    logic             vec_valid;
    logic             vec_ready;
    logic [N*D_W-1:0] x_vec;
    logic [N*D_W-1:0] y_vec;
    logic             vec_last;
    logic             data_in_x;
    logic             data_in_y;
    logic             load_en;
    logic             init;
    logic             busy;
    logic             done;

    modport master (
        output vec_valid, x_vec, y_vec, vec_last,
        input  vec_ready, data_in_x, data_in_y, load_en, init, busy, done
    );

    modport slave (
        input  vec_valid, x_vec, y_vec, vec_last,
        output vec_ready, data_in_x, data_in_y, load_en, init, busy, done
    );
endinterface

// File: rtl/operand_serializer.sv
// Bit-serial operand transmitter: shifts parallel x/y vectors out on two lockstep lanes,
// then issues a one-cycle init/done pulse after the vector flagged last.
module operand_serializer #(
    parameter int D_W     = 8,
    parameter int N       = 2,
    parameter int GAP_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    operand_serializer_if.slave  bus
);
    localparam int W  = N * D_W;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);
    localparam logic [CW-1:0] PRE_IDX  = CW'((W > 1) ? (W - 2) : 0);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [3:0]    GAP_LAST = 4'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        INIT  = 2'd3
    } state_t;

    state_t          state_r;
    logic [W-1:0]    x_sh_r;
    logic [W-1:0]    y_sh_r;
    logic            last_r;
    logic [CW-1:0]   bit_cnt_r;
    logic [3:0]      gap_cnt_r;
    logic            data_x_r;
    logic            data_y_r;
    logic            load_en_r;
    logic            init_r;
    logic            done_r;
    logic            busy_r;
    logic            vec_ready_r;

    logic [W-1:0]    x_ser_s;
    logic [W-1:0]    y_ser_s;
    logic            accept_s;

    // Reorder elements so element 0 sits in the top bits; each element keeps MSB on top,
    // so shifting left from the top yields element 0 MSB first.
    for (genvar k = 0; k < N; k++) begin : g_order
        assign x_ser_s[W-(k+1)*D_W +: D_W] = bus.x_vec[k*D_W +: D_W];
        assign y_ser_s[W-(k+1)*D_W +: D_W] = bus.y_vec[k*D_W +: D_W];
    end

    // vec_ready is only ever high in IDLE or the final SHIFT cycle of a non-last vector.
    assign accept_s = bus.vec_valid & vec_ready_r;

    // Serializer state machine with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            x_sh_r      <= '0;
            y_sh_r      <= '0;
            last_r      <= 1'b0;
            bit_cnt_r   <= '0;
            gap_cnt_r   <= 4'd0;
            data_x_r    <= 1'b0;
            data_y_r    <= 1'b0;
            load_en_r   <= 1'b0;
            init_r      <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            vec_ready_r <= 1'b1;
        end else if (accept_s) begin
            state_r     <= SHIFT;
            x_sh_r      <= x_ser_s << 1;
            y_sh_r      <= y_ser_s << 1;
            data_x_r    <= x_ser_s[W-1];
            data_y_r    <= y_ser_s[W-1];
            last_r      <= bus.vec_last;
            bit_cnt_r   <= '0;
            load_en_r   <= 1'b1;
            init_r      <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b1;
            vec_ready_r <= (LAST_IDX == '0) && !bus.vec_last;
        end else begin
            case (state_r)
                IDLE: begin
                    data_x_r    <= 1'b0;
                    data_y_r    <= 1'b0;
                    load_en_r   <= 1'b0;
                    busy_r      <= 1'b0;
                    vec_ready_r <= 1'b1;
                end
                SHIFT: begin
                    if (bit_cnt_r != LAST_IDX) begin
                        data_x_r    <= x_sh_r[W-1];
                        data_y_r    <= y_sh_r[W-1];
                        x_sh_r      <= x_sh_r << 1;
                        y_sh_r      <= y_sh_r << 1;
                        bit_cnt_r   <= bit_cnt_r + CNT_ONE;
                        vec_ready_r <= (bit_cnt_r == PRE_IDX) && !last_r;
                    end else if (last_r) begin
                        data_x_r    <= 1'b0;
                        data_y_r    <= 1'b0;
                        load_en_r   <= 1'b0;
                        vec_ready_r <= 1'b0;
                        gap_cnt_r   <= 4'd0;
                        if (GAP_CYC > 0) begin
                            state_r <= GAP;
                        end else begin
                            state_r <= INIT;
                            init_r  <= 1'b1;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r     <= IDLE;
                        data_x_r    <= 1'b0;
                        data_y_r    <= 1'b0;
                        load_en_r   <= 1'b0;
                        busy_r      <= 1'b0;
                        vec_ready_r <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        state_r <= INIT;
                        init_r  <= 1'b1;
                        done_r  <= 1'b1;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 4'd1;
                    end
                end
                INIT: begin
                    state_r     <= IDLE;
                    init_r      <= 1'b0;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    vec_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= IDLE;
                    data_x_r    <= 1'b0;
                    data_y_r    <= 1'b0;
                    load_en_r   <= 1'b0;
                    init_r      <= 1'b0;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    vec_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.data_in_x = data_x_r;
    assign bus.data_in_y = data_y_r;
    assign bus.load_en   = load_en_r;
    assign bus.init      = init_r;
    assign bus.done      = done_r;
    assign bus.busy      = busy_r;
    assign bus.vec_ready = vec_ready_r;
endmodule

// File: tb/tb_operand_serializer.sv
// Bench for operand_serializer: a queue-of-cycles model checked every cycle on two instances
// (GAP_CYC=2 and GAP_CYC=0), plus directed jobs with hand-computed bitstreams and timings.
module tb_operand_serializer;
    localparam int D_W = 8;
    localparam int N   = 2;

    typedef struct packed {
        logic x;
        logic y;
        logic le;
        logic ini;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] x_v = 16'h0000;
    logic [15:0] y_v = 16'h0000;
    logic        last_v = 1'b0;
    logic        va = 1'b0;
    logic        vb = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    rec_t qa[$];
    rec_t qb[$];

    logic [15:0] s_x, s_y;
    int s_le, s_le_last, s_init, s_init_at, s_rdy, s_rdy_sum, s_both;
    logic s_idle_end;

    always #5 clk = ~clk;

    operand_serializer_if #(.D_W(D_W), .N(N)) bus_a ();
    operand_serializer_if #(.D_W(D_W), .N(N)) bus_b ();

    assign bus_a.vec_valid = va;
    assign bus_a.x_vec     = x_v;
    assign bus_a.y_vec     = y_v;
    assign bus_a.vec_last  = last_v;
    assign bus_b.vec_valid = vb;
    assign bus_b.x_vec     = x_v;
    assign bus_b.y_vec     = y_v;
    assign bus_b.vec_last  = last_v;

    operand_serializer #(.D_W(D_W), .N(N), .GAP_CYC(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    operand_serializer #(.D_W(D_W), .N(N), .GAP_CYC(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    logic [6:0] act_a, act_b;
    assign act_a = {bus_a.data_in_x, bus_a.data_in_y, bus_a.load_en, bus_a.init,
                    bus_a.done, bus_a.busy, bus_a.vec_ready};
    assign act_b = {bus_b.data_in_x, bus_b.data_in_y, bus_b.load_en, bus_b.init,
                    bus_b.done, bus_b.busy, bus_b.vec_ready};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit i of the serial stream: element 0 before element 1, MSB first within an element.
    function automatic rec_t bit_rec(input int i, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] tx, ty;
        tx = {x[7:0], y[7:0]} == 16'h0000 ? 16'h0000 : 16'h0000;
        tx = {x[7:0], x[15:8]} << i;
        ty = {y[7:0], y[15:8]} << i;
        return {tx[15], ty[15], 1'b1, 1'b0};
    endfunction

    // Expected {x, y, load_en, init, done, busy, vec_ready} given the pending-cycle queue.
    function automatic logic [6:0] exp_tuple(input int sz, input rec_t f);
        return {f.x, f.y, f.le, f.ini, f.ini, (sz > 0), (sz == 0) || (sz == 1 && f.le)};
    endfunction

    // Model for the GAP_CYC=2 instance: each queue entry is one future output cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete();
        end else if (va && (qa.size() == 0 || (qa.size() == 1 && qa[0].le))) begin
            if (qa.size() > 0) void'(qa.pop_front());
            for (int i = 0; i < 16; i++) qa.push_back(bit_rec(i, x_v, y_v));
            if (last_v) begin
                for (int g = 0; g < 2; g++) qa.push_back(4'b0000);
                qa.push_back(4'b0001);
            end
        end else if (qa.size() > 0) begin
            void'(qa.pop_front());
        end
    end

    // Model for the GAP_CYC=0 instance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qb.delete();
        end else if (vb && (qb.size() == 0 || (qb.size() == 1 && qb[0].le))) begin
            if (qb.size() > 0) void'(qb.pop_front());
            for (int i = 0; i < 16; i++) qb.push_back(bit_rec(i, x_v, y_v));
            if (last_v) qb.push_back(4'b0001);
        end else if (qb.size() > 0) begin
            void'(qb.pop_front());
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst || qa.size() > 0 || qb.size() > 0 || !rst) begin
            check("cycle_a", {25'd0, act_a}, {25'd0, exp_tuple(qa.size(), (qa.size() > 0) ? qa[0] : 4'b0000)});
            check("cycle_b", {25'd0, act_b}, {25'd0, exp_tuple(qb.size(), (qb.size() > 0) ? qb[0] : 4'b0000)});
        end
    end

    // One job: handshake, then ncyc sampled cycles. mode 0 plain, 1 host noise,
    // 2 three back-to-back vectors, 3 reset at bit 5.
    task automatic run_job(input bit lb, input logic [15:0] x, input logic [15:0] y,
                           input bit last, input int ncyc, input int mode);
        logic dx, dy, le, ini, rdy, bsy;
        @(negedge clk);
        x_v = x; y_v = y; last_v = last;
        if (lb) vb = 1'b1; else va = 1'b1;
        check("hs_ready", {31'd0, (lb ? bus_b.vec_ready : bus_a.vec_ready)}, 32'd1);
        s_x = 16'h0000; s_y = 16'h0000; s_le = 0; s_le_last = 0; s_init = 0; s_init_at = 0;
        s_rdy = 0; s_rdy_sum = 0; s_both = 0; s_idle_end = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            dx  = lb ? bus_b.data_in_x : bus_a.data_in_x;
            dy  = lb ? bus_b.data_in_y : bus_a.data_in_y;
            le  = lb ? bus_b.load_en   : bus_a.load_en;
            ini = lb ? bus_b.init      : bus_a.init;
            rdy = lb ? bus_b.vec_ready : bus_a.vec_ready;
            bsy = lb ? bus_b.busy      : bus_a.busy;
            if (le) begin
                s_x = {s_x[14:0], dx}; s_y = {s_y[14:0], dy};
                s_le++; s_le_last = i;
                if (rdy) begin s_rdy++; s_rdy_sum += i; end
            end
            if (ini) begin s_init++; s_init_at = i; end
            if (le && ini) s_both++;
            if (i == ncyc) s_idle_end = rdy && !bsy;
            if (i == 1 && mode != 2) begin va = 1'b0; vb = 1'b0; end
            if (mode == 1 && i == 5) begin va = 1'b1; x_v = 16'hFFFF; y_v = 16'hFFFF; end
            if (mode == 1 && i == 18) va = 1'b0;
            if (mode == 2 && i == 1) begin x_v = 16'h5AF0; y_v = 16'h0F0F; end
            if (mode == 2 && i == 17) begin x_v = 16'h0381; y_v = 16'h7F00; last_v = 1'b1; end
            if (mode == 2 && i == 33) va = 1'b0;
            if (mode == 3 && i == 5) begin
                #2 rst = 1'b1;
                #1 check("async_reset", {25'd0, act_a}, 32'h01);
            end
            if (mode == 3 && i == 6) rst = 1'b0;
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_a", {25'd0, act_a}, 32'h01);
        check("reset_b", {25'd0, act_b}, 32'h01);
        rst = 1'b0;

        // Single last vector with host noise during SHIFT and GAP.
        run_job(1'b0, 16'h0381, 16'h7F00, 1'b1, 20, 1);
        check("t1_x_stream", {16'd0, s_x}, 32'h8103);
        check("t1_y_stream", {16'd0, s_y}, 32'h007F);
        check("t1_le_cnt", s_le, 32'd16);
        check("t1_le_last", s_le_last, 32'd16);
        check("t1_init_cnt", s_init, 32'd1);
        check("t1_init_at", s_init_at, 32'd19);

        // Three back-to-back vectors, last on the third.
        run_job(1'b0, 16'hA5C3, 16'h1234, 1'b0, 55, 2);
        check("b2b_le_cnt", s_le, 32'd48);
        check("b2b_le_last", s_le_last, 32'd48);
        check("b2b_rdy_cnt", s_rdy, 32'd2);
        check("b2b_rdy_pos", s_rdy_sum, 32'd48);
        check("b2b_init_cnt", s_init, 32'd1);
        check("b2b_init_at", s_init_at, 32'd51);
        check("b2b_x_tail", {16'd0, s_x}, 32'h8103);

        // Non-last vector returns to IDLE without init.
        run_job(1'b0, 16'h00FF, 16'hFF00, 1'b0, 18, 0);
        check("nl_x_stream", {16'd0, s_x}, 32'hFF00);
        check("nl_y_stream", {16'd0, s_y}, 32'h00FF);
        check("nl_init_cnt", s_init, 32'd0);
        check("nl_idle_end", {31'd0, s_idle_end}, 32'd1);

        // GAP_CYC=0 instance.
        run_job(1'b1, 16'h8001, 16'h0180, 1'b1, 20, 0);
        check("g0_x_stream", {16'd0, s_x}, 32'h0180);
        check("g0_y_stream", {16'd0, s_y}, 32'h8001);
        check("g0_init_at", s_init_at, 32'd17);
        check("g0_overlap", s_both, 32'd0);

        // Reset mid-shift, then a clean vector.
        run_job(1'b0, 16'hC3A5, 16'h5A3C, 1'b1, 25, 3);
        check("rst_le_cnt", s_le, 32'd5);
        check("rst_init_cnt", s_init, 32'd0);
        run_job(1'b0, 16'h0381, 16'h7F00, 1'b0, 18, 0);
        check("post_rst_x", {16'd0, s_x}, 32'h8103);
        check("post_rst_y", {16'd0, s_y}, 32'h007F);
        check("post_rst_idle", {31'd0, s_idle_end}, 32'd1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
